// File: rtl/parity_stream_checker_if.sv
// -----------------------------------------------------------------------------
// parity_stream_checker_if
// Groups the input stream, output result stream and running-parity signals of
// parity_stream_checker.
//   slave  : the checker side (consumes the input beats, produces the result).
//   master : the environment side (drives beats, accepts results).
// Parameters:
//   WIDTH     : data bits per beat.
//   MAX_BEATS : saturation limit of the beat counter.
//   CNT_W     : derived beat-counter width.
// -----------------------------------------------------------------------------
interface parity_stream_checker_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
);
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  // Input stream
  logic             io_mode_odd;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_in_last;
  logic             io_in_expected;

  // Result stream
  logic             io_out_valid;
  logic             io_out_ready;
  logic             io_out_parity;
  logic [CNT_W-1:0] io_out_beats;
  logic             io_out_overflow;
  logic             io_out_err;

  // Running parity of the frame in progress
  logic             io_running;

  modport slave (
    input  io_mode_odd,
    input  io_in_valid,
    output io_in_ready,
    input  io_in_bits,
    input  io_in_last,
    input  io_in_expected,
    output io_out_valid,
    input  io_out_ready,
    output io_out_parity,
    output io_out_beats,
    output io_out_overflow,
    output io_out_err,
    output io_running
  );

  modport master (
    output io_mode_odd,
    output io_in_valid,
    input  io_in_ready,
    output io_in_bits,
    output io_in_last,
    output io_in_expected,
    input  io_out_valid,
    output io_out_ready,
    input  io_out_parity,
    input  io_out_beats,
    input  io_out_overflow,
    input  io_out_err,
    input  io_running
  );

endinterface

// File: rtl/parity_stream_checker.sv
// -----------------------------------------------------------------------------
// parity_stream_checker
// Accumulates even/odd parity over multi-beat frames of WIDTH-bit words and
// emits one registered result per frame (parity, saturating beat count,
// overflow flag, optional mismatch flag) on a ready/valid output.
//
// Ports:
//   clock : rising-edge clock.
//   reset : synchronous, active-high reset.
//   bus   : parity_stream_checker_if.slave
//           in  : io_mode_odd, io_in_valid/ready, io_in_bits, io_in_last,
//                 io_in_expected
//           out : io_out_valid/ready, io_out_parity, io_out_beats,
//                 io_out_overflow, io_out_err
//           io_running : registered running parity of the current frame.
//
// Build option:
//   PARITY_ERR_CHECK_EN : when defined, the final parity is compared against
//   io_in_expected (sampled with the last beat) and io_out_err reports a
//   mismatch. When undefined, io_out_err is tied low and io_in_expected is
//   ignored.
// -----------------------------------------------------------------------------
module parity_stream_checker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input logic                   clock,
  input logic                   reset,
  parity_stream_checker_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MaxBeats = CNT_W'(MAX_BEATS);

  state_e           r_state, w_state_next;
  logic             r_acc, w_acc_next;
  logic [CNT_W-1:0] r_beats, w_beats_next;
  logic             r_ovf, w_ovf_next;

  logic             w_in_ready;
  logic             w_fire;
  logic             w_beat_par;
  logic             w_frame_done;
  logic             w_release;

  assign w_beat_par = ^bus.io_in_bits;
  assign w_in_ready = (r_state != StHold);
  assign w_fire     = bus.io_in_valid && w_in_ready;
  assign w_release  = (r_state == StHold) && bus.io_out_ready;

  // Next-state / datapath
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_beats_next = r_beats;
    w_ovf_next   = r_ovf;
    w_frame_done = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_fire) begin
          // Odd mode seeds the accumulator with 1; mode is only sampled here.
          w_acc_next   = w_beat_par ^ bus.io_mode_odd;
          w_beats_next = CNT_W'(1);
          w_ovf_next   = 1'b0;
          if (bus.io_in_last) begin
            w_state_next = StHold;
            w_frame_done = 1'b1;
          end else begin
            w_state_next = StAccum;
          end
        end
      end

      StAccum: begin
        if (w_fire) begin
          // Parity keeps covering beats past the limit; only the count saturates.
          w_acc_next = r_acc ^ w_beat_par;
          if (r_beats == MaxBeats) begin
            w_ovf_next = 1'b1;
          end else begin
            w_beats_next = r_beats + CNT_W'(1);
          end
          if (bus.io_in_last) begin
            w_state_next = StHold;
            w_frame_done = 1'b1;
          end
        end
      end

      StHold: begin
        if (bus.io_out_ready) begin
          w_state_next = StIdle;
          w_acc_next   = 1'b0;
        end
      end

      default: begin
        w_state_next = StIdle;
        w_acc_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
      r_acc   <= 1'b0;
      r_beats <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_beats <= w_beats_next;
      r_ovf   <= w_ovf_next;
    end
  end

`ifdef PARITY_ERR_CHECK_EN
  logic r_err, w_err_next;

  always_comb begin
    w_err_next = r_err;
    if (w_frame_done) begin
      w_err_next = w_acc_next ^ bus.io_in_expected;
    end else if (w_release) begin
      w_err_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_next;
    end
  end

  assign bus.io_out_err = r_err;
`else
  // Port kept for interface compatibility; no comparison logic is built.
  logic w_unused_expected;
  logic w_unused_done;
  logic w_unused_release;
  assign w_unused_expected = bus.io_in_expected;
  assign w_unused_done     = w_frame_done;
  assign w_unused_release  = w_release;
  assign bus.io_out_err    = 1'b0;
`endif

  // Outputs: all derived from registered state.
  assign bus.io_in_ready     = w_in_ready;
  assign bus.io_out_valid    = (r_state == StHold);
  assign bus.io_out_parity   = r_acc;
  assign bus.io_out_beats    = r_beats;
  assign bus.io_out_overflow = r_ovf;
  assign bus.io_running      = (r_state == StIdle) ? 1'b0 : r_acc;

endmodule
